// File: rtl/frame_port_arbiter.sv
// Shares one memory write/bypass port between the CPU data side and a graphics engine write stream.
// Optional statistics counters are built when FRAME_ARB_STATS_EN is defined.
//
// state    | meaning
// CPU_PRI  | CPU wins contested cycles; the streak counter tracks consecutive wins
// ENG_TURN | engine is owed a slot; it wins the next contested cycle
module frame_port_arbiter #(
    parameter int unsigned MAX_CPU_STREAK = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_we,
    input  logic              cpu_re,
    input  logic [31:0]       cpu_din,
    output logic [31:0]       cpu_dout,
    output logic              cpu_stall,
    input  logic              eng_valid,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [3:0]        eng_we,
    input  logic [31:0]       eng_din,
    output logic              eng_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic              mem_re,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       stat_conflicts,
    output logic [31:0]       stat_eng_forced
);

    typedef enum logic {
        CPU_PRI  = 1'b0,
        ENG_TURN = 1'b1
    } state_t;

    localparam logic [8:0] STREAK_MAX = 9'(MAX_CPU_STREAK);

    state_t      state, state_nxt;
    logic [7:0]  streak, streak_nxt;
    logic [8:0]  streak_inc;
    logic        cpu_req, contested;
    logic        gnt_cpu, gnt_eng;
    logic        rd_tag;
    logic [31:0] rd_capture;

    assign cpu_req    = cpu_re | (|cpu_we);
    assign contested  = cpu_req & eng_valid;
    assign streak_inc = {1'b0, streak} + 9'd1;

    // Grants are suppressed during reset so nothing reaches the memory that cycle.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_eng = 1'b0;
        if (!rst) begin
            case (state)
                CPU_PRI: begin
                    if (cpu_req)        gnt_cpu = 1'b1;
                    else if (eng_valid) gnt_eng = 1'b1;
                end
                ENG_TURN: begin
                    if (eng_valid)      gnt_eng = 1'b1;
                    else if (cpu_req)   gnt_cpu = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        if (gnt_eng || !eng_valid) begin
            state_nxt  = CPU_PRI;
            streak_nxt = 8'd0;
        end else if (contested && gnt_cpu) begin
            if (streak_inc >= STREAK_MAX) begin
                state_nxt  = ENG_TURN;
                streak_nxt = 8'd0;
            end else begin
                streak_nxt = streak_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CPU_PRI;
            streak     <= 8'd0;
            rd_tag     <= 1'b0;
            rd_capture <= 32'd0;
        end else begin
            state      <= state_nxt;
            streak     <= streak_nxt;
            rd_tag     <= gnt_cpu & cpu_re;
            if (rd_tag)
                rd_capture <= mem_dout;
        end
    end

    assign mem_addr  = gnt_eng ? eng_addr : cpu_addr;
    assign mem_din   = gnt_eng ? eng_din  : cpu_din;
    assign mem_we    = gnt_eng ? eng_we : (gnt_cpu ? cpu_we : 4'd0);
    assign mem_re    = gnt_cpu & cpu_re;
    assign eng_ready = gnt_eng;
    assign cpu_stall = cpu_req & gnt_eng;
    assign cpu_dout  = rst ? 32'd0 : (rd_tag ? mem_dout : rd_capture);

`ifdef FRAME_ARB_STATS_EN
    logic [31:0] conflicts_q, forced_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflicts_q <= 32'd0;
            forced_q    <= 32'd0;
        end else begin
            if (contested)
                conflicts_q <= conflicts_q + 32'd1;
            if (gnt_eng && (state == ENG_TURN) && cpu_req)
                forced_q <= forced_q + 32'd1;
        end
    end

    assign stat_conflicts  = conflicts_q;
    assign stat_eng_forced = forced_q;
`else
    assign stat_conflicts  = 32'd0;
    assign stat_eng_forced = 32'd0;
`endif

endmodule

// File: tb/tb_frame_port_arbiter.sv
// Scoreboard bench for frame_port_arbiter: directed vectors push expected port values, a negedge monitor compares.
module tb_frame_port_arbiter;

    localparam logic [31:0] CA   = 32'h1000_0010;
    localparam logic [31:0] CD   = 32'hDEAD_BEEF;
    localparam logic [31:0] EA   = 32'h1F80_0000;
    localparam logic [31:0] ED   = 32'h00FF_00FF;
    localparam logic [31:0] RA   = 32'h1000_0004;
    localparam logic [31:0] RDAT = 32'h1234_5678;
    localparam logic [3:0]  EWE  = 4'h3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = CA;
    logic [3:0]  cpu_we = 4'd0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_din = CD;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        eng_valid = 1'b0;
    logic [31:0] eng_addr = EA;
    logic [3:0]  eng_we = EWE;
    logic [31:0] eng_din = ED;
    logic        eng_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic [31:0] stat_conflicts;
    logic [31:0] stat_eng_forced;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
        logic        re;
        logic        rdy;
        logic        stall;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [31:0] ram [16];

    frame_port_arbiter #(.MAX_CPU_STREAK(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .eng_valid(eng_valid), .eng_addr(eng_addr), .eng_we(eng_we), .eng_din(eng_din),
        .eng_ready(eng_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
        .mem_dout(mem_dout),
        .stat_conflicts(stat_conflicts), .stat_eng_forced(stat_eng_forced)
    );

    always #5 clk = ~clk;

    // Block-RAM model: one-cycle read latency, word indexed by address bits 5:2.
    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'd0;
        ram[1] = RDAT;
    end

    always @(posedge clk) begin
        if (|mem_we) ram[mem_addr[5:2]] <= mem_din;
        if (mem_re)  mem_dout <= ram[mem_addr[5:2]];
    end

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h at %0t", nm, field, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "mem_addr",  mem_addr, e.addr);
            chk(e.nm, "mem_din",   mem_din, e.din);
            chk(e.nm, "mem_we",    {28'd0, mem_we}, {28'd0, e.we});
            chk(e.nm, "mem_re",    {31'd0, mem_re}, {31'd0, e.re});
            chk(e.nm, "eng_ready", {31'd0, eng_ready}, {31'd0, e.rdy});
            chk(e.nm, "cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
            chk(e.nm, "cpu_dout",  cpu_dout, e.dout);
        end
    end

    // Drive one cycle of inputs and queue the response: x_eng means the engine owns the port.
    task automatic step(input string nm, input logic r, input logic cre, input logic [3:0] cwe,
                        input logic [31:0] caddr, input logic ev, input logic [3:0] xwe,
                        input logic xre, input logic x_eng, input logic xstall,
                        input logic [31:0] xdout);
        exp_t x;
        rst       = r;
        cpu_re    = cre;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        eng_valid = ev;
        x.nm    = nm;
        x.addr  = x_eng ? EA : caddr;
        x.din   = x_eng ? ED : CD;
        x.we    = xwe;
        x.re    = xre;
        x.rdy   = x_eng;
        x.stall = xstall;
        x.dout  = xdout;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_conf, exp_forced;
`ifdef FRAME_ARB_STATS_EN
        exp_conf   = 32'd10;
        exp_forced = 32'd2;
`else
        exp_conf   = 32'd0;
        exp_forced = 32'd0;
`endif
        @(posedge clk);
        #1;

        // Reset with a contested stream present
        step("rst", 1, 0, 4'hF, CA, 1, 4'h0, 0, 0, 0, 32'd0);
        step("rst", 1, 0, 4'hF, CA, 1, 4'h0, 0, 0, 0, 32'd0);

        step("cpu_wr", 0, 0, 4'hF, CA, 0, 4'hF, 0, 0, 0, 32'd0);
        step("cpu_wr", 0, 0, 4'hF, CA, 0, 4'hF, 0, 0, 0, 32'd0);

        step("eng_wr", 0, 0, 4'h0, CA, 1, EWE, 0, 1, 0, 32'd0);

        // Held contention at MAX_CPU_STREAK = 4: engine forced in on cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                step("streak_eng", 0, 0, 4'hF, CA, 1, EWE, 0, 1, 1, 32'd0);
            else
                step("streak_cpu", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, 32'd0);
        end
        chk("stats", "stat_conflicts", stat_conflicts, exp_conf);
        chk("stats", "stat_eng_forced", stat_eng_forced, exp_forced);

        // Read return and hold across an engine write
        step("rd_issue", 0, 1, 4'h0, RA, 0, 4'h0, 1, 0, 0, 32'd0);
        step("rd_data",  0, 0, 4'h0, RA, 1, EWE,  0, 1, 0, RDAT);
        step("rd_hold",  0, 0, 4'h0, RA, 0, 4'h0, 0, 0, 0, RDAT);

        // Enter ENG_TURN, then drop eng_valid before the engine is granted
        for (int i = 0; i < 4; i++)
            step("pre_turn", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, RDAT);
        step("turn_drop", 0, 0, 4'hF, CA, 0, 4'hF, 0, 0, 0, RDAT);

        // Streak restarts from 0; the forced slot lands on a CPU read
        for (int i = 0; i < 4; i++)
            step("rd_cpu", 0, 1, 4'h0, CA, 1, 4'h0, 1, 0, 0, (i == 0) ? RDAT : CD);
        step("rd_stall", 0, 1, 4'h0, CA, 1, EWE,  0, 1, 1, CD);
        step("rd_after", 0, 1, 4'h0, CA, 0, 4'h0, 1, 0, 0, CD);
        step("rd_ret",   0, 0, 4'h0, CA, 0, 4'h0, 0, 0, 0, CD);

        // Reset in the middle of a contested stream
        step("pre_rst", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, CD);
        step("pre_rst", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, CD);
        step("rst_mid", 1, 0, 4'hF, CA, 1, 4'h0, 0, 0, 0, 32'd0);

        // Reset while in ENG_TURN: no engine grant, CPU_PRI afterwards
        for (int i = 0; i < 4; i++)
            step("to_turn", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, 32'd0);
        step("rst_turn", 1, 0, 4'hF, CA, 1, 4'h0, 0, 0, 0, 32'd0);
        step("post_rst", 0, 0, 4'hF, CA, 1, 4'hF, 0, 0, 0, 32'd0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
